// File: rtl/iter_alu.sv
// Multi-cycle ALU with a valid/ready handshake; shifts and multiply iterate one bit per clock.
// Define ITER_ALU_EARLY_TERM_EN to let MUL stop once the remaining multiplier bits are all zero.
module iter_alu #(
   parameter int WIDTH = 16,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [3:0]       func_code,
   input  logic [1:0]       branch_type,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] C,
   output logic             overflow_flag,
   output logic             bcond
);

   // state  | meaning
   // S_IDLE | ready for a new op; single-cycle ops complete on the accept edge
   // S_BUSY | iterating a variable shift or the shift-add multiply
   // S_DONE | result, flags and bcond held until out_ready

   localparam int CW = SHW + 1;

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_AND  = 4'd2;
   localparam logic [3:0] OP_ORR  = 4'd3;
   localparam logic [3:0] OP_NOT  = 4'd4;
   localparam logic [3:0] OP_TCP  = 4'd5;
   localparam logic [3:0] OP_SHL  = 4'd6;
   localparam logic [3:0] OP_SHR  = 4'd7;
   localparam logic [3:0] OP_SHLV = 4'd8;
   localparam logic [3:0] OP_SHRV = 4'd9;
   localparam logic [3:0] OP_MUL  = 4'd10;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [3:0]         op_q, op_d;
   logic [1:0]         bt_q, bt_d;
   logic [2*WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0]   mplier_q, mplier_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [WIDTH-1:0]   c_q, c_d;
   logic               ovf_q, ovf_d;
   logic               bcond_q, bcond_d;

   logic               accept;
   logic [SHW-1:0]     shamt;
   logic [WIDTH-1:0]   sum, diff;
   logic [WIDTH-1:0]   quick_c;
   logic               quick_ovf;
   logic [WIDTH-1:0]   sh_cur, sh_next;
   logic [2*WIDTH-1:0] acc_next;
   logic               shift_last, mul_last;

   function automatic logic branch_eval(input logic [WIDTH-1:0] c, input logic [1:0] bt);
      logic r;
      r = 1'b0;
      case (bt)
         2'd0:    r = (c != '0);
         2'd1:    r = (c == '0);
         2'd2:    r = !c[WIDTH-1] && (c != '0);
         default: r = c[WIDTH-1];
      endcase
      return r;
   endfunction

   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = (state_q == S_DONE);
   assign accept    = in_valid && in_ready;
   assign shamt     = B[SHW-1:0];

   assign C             = c_q;
   assign overflow_flag = ovf_q;
   assign bcond         = bcond_q;

   // Ops that finish on the accept edge, computed straight from the input operands.
   always_comb begin
      quick_c   = '0;
      quick_ovf = 1'b0;
      sum       = A + B;
      diff      = A - B;
      case (func_code)
         OP_ADD: begin
            quick_c   = sum;
            quick_ovf = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
         end
         OP_SUB: begin
            quick_c   = diff;
            quick_ovf = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
         end
         OP_AND:  quick_c = A & B;
         OP_ORR:  quick_c = A | B;
         OP_NOT:  quick_c = ~A;
         OP_TCP:  quick_c = (~A) + {{(WIDTH-1){1'b0}}, 1'b1};
         OP_SHL:  quick_c = {A[WIDTH-2:0], 1'b0};
         OP_SHR:  quick_c = {A[WIDTH-1], A[WIDTH-1:1]};
         OP_SHLV: quick_c = A;
         OP_SHRV: quick_c = A;
         default: quick_c = '0;
      endcase
   end

   // One iteration step; the shifter reuses the low half of the multiplicand register.
   always_comb begin
      sh_cur     = mcand_q[WIDTH-1:0];
      sh_next    = (op_q == OP_SHRV) ? {sh_cur[WIDTH-1], sh_cur[WIDTH-1:1]}
                                     : {sh_cur[WIDTH-2:0], 1'b0};
      acc_next   = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
      shift_last = (cnt_q == CW'(1));
`ifdef ITER_ALU_EARLY_TERM_EN
      mul_last   = (cnt_q == CW'(1)) || (mplier_q[WIDTH-1:1] == '0);
`else
      mul_last   = (cnt_q == CW'(1));
`endif
   end

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      bt_d     = bt_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      c_d      = c_q;
      ovf_d    = ovf_q;
      bcond_d  = bcond_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               op_d     = func_code;
               bt_d     = branch_type;
               mcand_d  = {{WIDTH{1'b0}}, A};
               mplier_d = B;
               acc_d    = '0;
               if (func_code == OP_MUL) begin
                  cnt_d   = CW'(WIDTH);
                  state_d = S_BUSY;
               end else if ((func_code == OP_SHLV || func_code == OP_SHRV) && shamt != '0) begin
                  cnt_d   = {1'b0, shamt};
                  state_d = S_BUSY;
               end else begin
                  c_d     = quick_c;
                  ovf_d   = quick_ovf;
                  bcond_d = branch_eval(quick_c, branch_type);
                  state_d = S_DONE;
               end
            end
         end
         S_BUSY: begin
            cnt_d = cnt_q - CW'(1);
            if (op_q == OP_MUL) begin
               acc_d    = acc_next;
               mcand_d  = mcand_q << 1;
               mplier_d = mplier_q >> 1;
               if (mul_last) begin
                  c_d     = acc_next[WIDTH-1:0];
                  ovf_d   = |acc_next[2*WIDTH-1:WIDTH];
                  bcond_d = branch_eval(acc_next[WIDTH-1:0], bt_q);
                  state_d = S_DONE;
               end
            end else begin
               mcand_d = {{WIDTH{1'b0}}, sh_next};
               if (shift_last) begin
                  c_d     = sh_next;
                  ovf_d   = 1'b0;
                  bcond_d = branch_eval(sh_next, bt_q);
                  state_d = S_DONE;
               end
            end
         end
         S_DONE: begin
            if (out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         op_q     <= '0;
         bt_q     <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         c_q      <= '0;
         ovf_q    <= 1'b0;
         bcond_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         bt_q     <= bt_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         c_q      <= c_d;
         ovf_q    <= ovf_d;
         bcond_q  <= bcond_d;
      end
   end

endmodule

// File: tb/tb_iter_alu.sv
// Scoreboard bench for iter_alu (WIDTH=16); expected latencies follow ITER_ALU_EARLY_TERM_EN.
module tb_iter_alu;

   localparam int W = 16;

   logic         clk = 1'b0;
   logic         reset;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] A, B, C;
   logic [3:0]   func_code;
   logic [1:0]   branch_type;
   logic         out_valid;
   logic         out_ready;
   logic         overflow_flag;
   logic         bcond;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [W-1:0] c;
      logic         ovf;
      logic         bc;
      int           lat;
   } exp_t;

   typedef struct {
      logic [3:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [1:0]   bt;
   } stim_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   iter_alu #(.WIDTH(W)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .A(A), .B(B), .func_code(func_code), .branch_type(branch_type),
      .out_valid(out_valid), .out_ready(out_ready), .C(C),
      .overflow_flag(overflow_flag), .bcond(bcond)
   );

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
      $fatal(1, "watchdog");
   end

   function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a,
                                  input logic [W-1:0] b, input logic [1:0] bt);
      exp_t e;
      int sa, sbv, r, n, top;
      logic [2*W-1:0] p;
      sa    = int'($signed(a));
      sbv   = int'($signed(b));
      n     = int'(b[3:0]);
      e.c   = '0;
      e.ovf = 1'b0;
      e.lat = 1;
      case (op)
         4'd0: begin r = sa + sbv; e.c = r[W-1:0]; e.ovf = (r > 32767) || (r < -32768); end
         4'd1: begin r = sa - sbv; e.c = r[W-1:0]; e.ovf = (r > 32767) || (r < -32768); end
         4'd2: e.c = a & b;
         4'd3: e.c = a | b;
         4'd4: e.c = ~a;
         4'd5: begin r = 65536 - int'(a); e.c = r[W-1:0]; end
         4'd6: e.c = a << 1;
         4'd7: e.c = $signed(a) >>> 1;
         4'd8: begin e.c = a << n; e.lat = 1 + n; end
         4'd9: begin e.c = $signed(a) >>> n; e.lat = 1 + n; end
         4'd10: begin
            p     = {16'h0000, a} * {16'h0000, b};
            e.c   = p[W-1:0];
            e.ovf = (p[2*W-1:W] != 16'h0000);
            top   = 0;
            for (int i = 0; i < W; i++) if (b[i]) top = i + 1;
`ifdef ITER_ALU_EARLY_TERM_EN
            e.lat = 1 + ((top < 1) ? 1 : top);
`else
            e.lat = 1 + W;
`endif
         end
         default: e.c = '0;
      endcase
      case (bt)
         2'd0:    e.bc = (e.c != 0);
         2'd1:    e.bc = (e.c == 0);
         2'd2:    e.bc = ($signed(e.c) > 0);
         default: e.bc = ($signed(e.c) < 0);
      endcase
      return e;
   endfunction

   task automatic send(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [1:0] bt);
      int guard;
      sb.push_back(model(op, a, b, bt));
      @(negedge clk);
      guard = 0;
      while (!in_ready && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      if (!in_ready) begin
         errors++;
         $display("FAIL send_ready: in_ready stuck at %b, required 1", in_ready);
      end
      in_valid    = 1'b1;
      func_code   = op;
      A           = a;
      B           = b;
      branch_type = bt;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      A        = W'($urandom);
      B        = W'($urandom);
   endtask

   // Called #1 after the accept edge with out_ready=1; returns observed values and latency.
   task automatic collect(output logic [W-1:0] c, output logic ovf, output logic bc,
                          output int lat, output logic rdy_after);
      lat = 1;
      while (!out_valid && lat < 64) begin
         @(posedge clk);
         #1;
         lat++;
      end
      c   = C;
      ovf = overflow_flag;
      bc  = bcond;
      @(posedge clk);
      #1;
      rdy_after = in_ready && !out_valid;
   endtask

   task automatic test_reset();
      reset       = 1'b1;
      in_valid    = 1'b0;
      out_ready   = 1'b1;
      A           = '0;
      B           = '0;
      func_code   = '0;
      branch_type = '0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      checks++; if (C !== 16'h0000) begin errors++; $display("FAIL reset_C: got %h want 0000", C); end
      checks++; if (overflow_flag !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", overflow_flag); end
      checks++; if (bcond !== 1'b0) begin errors++; $display("FAIL reset_bcond: got %b want 0", bcond); end
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_single_cycle();
      stim_t tab[$];
      exp_t e;
      logic [W-1:0] c;
      logic o, bc, r;
      int lat;
      tab.push_back('{4'd0,  16'h7FFF, 16'h0001, 2'd3});
      tab.push_back('{4'd0,  16'h8000, 16'h8000, 2'd1});
      tab.push_back('{4'd1,  16'h8000, 16'h0001, 2'd2});
      tab.push_back('{4'd1,  16'h0003, 16'h0005, 2'd3});
      tab.push_back('{4'd2,  16'hF0F0, 16'h3C3C, 2'd0});
      tab.push_back('{4'd3,  16'h0000, 16'h0000, 2'd1});
      tab.push_back('{4'd4,  16'h00FF, 16'h1234, 2'd3});
      tab.push_back('{4'd5,  16'h0001, 16'h0000, 2'd3});
      tab.push_back('{4'd6,  16'hC001, 16'h0000, 2'd2});
      tab.push_back('{4'd7,  16'h8002, 16'h0000, 2'd3});
      tab.push_back('{4'd12, 16'hFFFF, 16'hFFFF, 2'd1});
      tab.push_back('{4'd15, 16'h7FFF, 16'h7FFF, 2'd0});
      foreach (tab[i]) begin
         send(tab[i].op, tab[i].a, tab[i].b, tab[i].bt);
         collect(c, o, bc, lat, r);
         e = sb.pop_front();
         checks++; if (c !== e.c) begin errors++; $display("FAIL single_C[%0d]: got %h want %h", i, c, e.c); end
         checks++; if (o !== e.ovf) begin errors++; $display("FAIL single_ovf[%0d]: got %b want %b", i, o, e.ovf); end
         checks++; if (bc !== e.bc) begin errors++; $display("FAIL single_bcond[%0d]: got %b want %b", i, bc, e.bc); end
         checks++; if (lat != e.lat) begin errors++; $display("FAIL single_latency[%0d]: got %0d want %0d", i, lat, e.lat); end
         checks++; if (r !== 1'b1) begin errors++; $display("FAIL single_release[%0d]: in_ready after release got %b want 1", i, r); end
      end
   endtask

   task automatic test_shifts();
      stim_t tab[$];
      exp_t e;
      logic [W-1:0] c;
      logic o, bc, r;
      int lat;
      tab.push_back('{4'd9, 16'h8004, 16'h0003, 2'd3});
      tab.push_back('{4'd8, 16'h0001, 16'hFFF0, 2'd0});
      tab.push_back('{4'd9, 16'h8000, 16'h000F, 2'd3});
      tab.push_back('{4'd8, 16'h0001, 16'h000F, 2'd3});
      tab.push_back('{4'd8, 16'h00F0, 16'h1234, 2'd2});
      tab.push_back('{4'd9, 16'h7F00, 16'hABC8, 2'd2});
      foreach (tab[i]) begin
         send(tab[i].op, tab[i].a, tab[i].b, tab[i].bt);
         collect(c, o, bc, lat, r);
         e = sb.pop_front();
         checks++; if (c !== e.c) begin errors++; $display("FAIL shift_C[%0d]: got %h want %h", i, c, e.c); end
         checks++; if (o !== e.ovf) begin errors++; $display("FAIL shift_ovf[%0d]: got %b want %b", i, o, e.ovf); end
         checks++; if (bc !== e.bc) begin errors++; $display("FAIL shift_bcond[%0d]: got %b want %b", i, bc, e.bc); end
         checks++; if (lat != e.lat) begin errors++; $display("FAIL shift_latency[%0d]: got %0d want %0d", i, lat, e.lat); end
         checks++; if (r !== 1'b1) begin errors++; $display("FAIL shift_release[%0d]: got %b want 1", i, r); end
      end
   endtask

   task automatic test_mul();
      stim_t tab[$];
      exp_t e;
      logic [W-1:0] c;
      logic o, bc, r;
      int lat;
      tab.push_back('{4'd10, 16'h0100, 16'h0100, 2'd1});
      tab.push_back('{4'd10, 16'h00FF, 16'h0003, 2'd2});
      tab.push_back('{4'd10, 16'h1234, 16'h0000, 2'd1});
      tab.push_back('{4'd10, 16'hFFFF, 16'hFFFF, 2'd0});
      tab.push_back('{4'd10, 16'h0003, 16'h8000, 2'd3});
      tab.push_back('{4'd10, 16'h00B5, 16'h0167, 2'd2});
      foreach (tab[i]) begin
         send(tab[i].op, tab[i].a, tab[i].b, tab[i].bt);
         collect(c, o, bc, lat, r);
         e = sb.pop_front();
         checks++; if (c !== e.c) begin errors++; $display("FAIL mul_C[%0d]: got %h want %h", i, c, e.c); end
         checks++; if (o !== e.ovf) begin errors++; $display("FAIL mul_ovf[%0d]: got %b want %b", i, o, e.ovf); end
         checks++; if (bc !== e.bc) begin errors++; $display("FAIL mul_bcond[%0d]: got %b want %b", i, bc, e.bc); end
         checks++; if (lat != e.lat) begin errors++; $display("FAIL mul_latency[%0d]: got %0d want %0d", i, lat, e.lat); end
         checks++; if (r !== 1'b1) begin errors++; $display("FAIL mul_release[%0d]: got %b want 1", i, r); end
      end
   endtask

   task automatic test_backpressure();
      exp_t e;
      int lat;
      out_ready = 1'b0;
      send(4'd1, 16'd5, 16'd5, 2'd1);
      e   = sb.pop_front();
      lat = 1;
      while (!out_valid && lat < 64) begin
         @(posedge clk);
         #1;
         lat++;
      end
      checks++; if (lat != e.lat) begin errors++; $display("FAIL bp_latency: got %0d want %0d", lat, e.lat); end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         in_valid  = ~in_valid;
         A         = W'($urandom);
         B         = W'($urandom);
         func_code = 4'd0;
         @(posedge clk);
         #1;
         checks++; if (C !== e.c) begin errors++; $display("FAIL bp_C[%0d]: got %h want %h", i, C, e.c); end
         checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid[%0d]: got %b want 1", i, out_valid); end
         checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d]: got %b want 0", i, in_ready); end
         checks++; if (bcond !== e.bc) begin errors++; $display("FAIL bp_bcond[%0d]: got %b want %b", i, bcond, e.bc); end
      end
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++; $display("FAIL bp_release: out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
      end
      @(posedge clk);
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_single_handshake: out_valid got %b want 0", out_valid); end
      checks++; if (C !== e.c || overflow_flag !== e.ovf) begin
         errors++; $display("FAIL bp_hold_after_release: C=%h ovf=%b want %h/%b", C, overflow_flag, e.c, e.ovf);
      end
   endtask

   task automatic test_reset_mid_op();
      exp_t e;
      logic [W-1:0] c;
      logic o, bc, r, seen;
      int lat;
      send(4'd0, 16'h7FFF, 16'h0001, 2'd3);
      collect(c, o, bc, lat, r);
      e = sb.pop_front();
      checks++; if (c !== e.c || o !== e.ovf || bc !== e.bc) begin
         errors++; $display("FAIL rst_pre_op: got %h/%b/%b want %h/%b/%b", c, o, bc, e.c, e.ovf, e.bc);
      end
      @(negedge clk);
      in_valid  = 1'b1;
      func_code = 4'd10;
      A         = 16'h1234;
      B         = 16'h5678;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_busy: out_valid got %b want 0", out_valid); end
      reset = 1'b1;
      @(posedge clk);
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_out_valid: got %b want 0", out_valid); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_in_ready: got %b want 1", in_ready); end
      checks++; if (C !== 16'h0000) begin errors++; $display("FAIL rst_mid_C: got %h want 0000", C); end
      checks++; if (overflow_flag !== 1'b0) begin errors++; $display("FAIL rst_mid_ovf: got %b want 0", overflow_flag); end
      checks++; if (bcond !== 1'b0) begin errors++; $display("FAIL rst_mid_bcond: got %b want 0", bcond); end
      @(negedge clk);
      reset = 1'b0;
      seen  = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         #1;
         if (out_valid) seen = 1'b1;
      end
      checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rst_abandoned: out_valid seen %b want 0", seen); end
      send(4'd0, 16'd2, 16'd3, 2'd0);
      collect(c, o, bc, lat, r);
      e = sb.pop_front();
      checks++; if (c !== e.c) begin errors++; $display("FAIL rst_post_add_C: got %h want %h", c, e.c); end
      checks++; if (lat != e.lat) begin errors++; $display("FAIL rst_post_add_latency: got %0d want %0d", lat, e.lat); end
   endtask

   task automatic test_back_to_back();
      exp_t e;
      logic [W-1:0] c;
      logic o, bc, r;
      logic [3:0] op;
      int lat;
      for (int i = 0; i < 24; i++) begin
         op = 4'($urandom_range(0, 15));
         send(op, W'($urandom), W'($urandom), 2'($urandom_range(0, 3)));
         collect(c, o, bc, lat, r);
         e = sb.pop_front();
         checks++; if (c !== e.c) begin errors++; $display("FAIL b2b_C[%0d] op %0d: got %h want %h", i, op, c, e.c); end
         checks++; if (o !== e.ovf) begin errors++; $display("FAIL b2b_ovf[%0d] op %0d: got %b want %b", i, op, o, e.ovf); end
         checks++; if (bc !== e.bc) begin errors++; $display("FAIL b2b_bcond[%0d] op %0d: got %b want %b", i, op, bc, e.bc); end
         checks++; if (lat != e.lat) begin errors++; $display("FAIL b2b_latency[%0d] op %0d: got %0d want %0d", i, op, lat, e.lat); end
      end
      checks++; if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size()); end
   endtask

   initial begin
      test_reset();
      test_single_cycle();
      test_shifts();
      test_mul();
      test_backpressure();
      test_reset_mid_op();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
